// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for the UART: first-word-fall-through, so a pushed word is on r_data right after its edge.
// Writes to a full FIFO are dropped and raise sticky overrun, unless a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DWIDTH = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DWIDTH-1:0] w_data,
  input  logic              rd,
  input  logic              clr_overrun,
  output logic [DWIDTH-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overrun
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overrun_q, overrun_d;
  logic              push, pop;

  // A pop from a full FIFO frees the slot the concurrent push needs.
  assign pop  = rd && !empty_q;
  assign push = wr && (!full_q || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
    empty_d = (level_d == '0);
    full_d  = (level_d == (ADDR_W+1)'(DEPTH));
    // Set beats clear when both happen in one cycle.
    if (wr && full_q && !rd) overrun_d = 1'b1;
    else if (clr_overrun)    overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately not reset; empty gating keeps stale contents invisible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= w_data;
  end

  assign r_data  = empty_q ? '0 : mem[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;
  assign level   = level_q;
  assign overrun = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DWIDTH, default 8: width of one received data word.
REQ-002 Parameter ADDR_W, default 4: address width; depth = 2**ADDR_W entries (16 by default).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; asserted while 0.
REQ-005 wr  input  1  write strobe, one clk pulse per received word; driven by the receiver's rx_done_tick.
REQ-006 w_data  input  DWIDTH  write data; driven by the receiver's dout and sampled when wr=1.
REQ-007 rd  input  1  read/pop strobe from the consumer.
REQ-008 clr_overrun  input  1  synchronous clear of the overrun flag.
REQ-009 r_data  output  DWIDTH  head-of-queue word, first-word-fall-through.
REQ-010 empty  output  1  high when the FIFO holds 0 entries.
REQ-011 full  output  1  high when the FIFO holds 2**ADDR_W entries.
REQ-012 level  output  ADDR_W+1  current number of stored entries.
REQ-013 overrun  output  1  sticky flag: a word was dropped because the FIFO was full.

Function
REQ-014 Storage SHALL be a 2**ADDR_W x DWIDTH register array with write pointer wr_ptr and read pointer rd_ptr, each ADDR_W bits wide.
REQ-015 A push (wr=1 and accepted) SHALL write w_data to mem[wr_ptr] and increment wr_ptr modulo 2**ADDR_W at the same edge.
REQ-016 A pop (rd=1 and accepted) SHALL increment rd_ptr modulo 2**ADDR_W; the popped word is the r_data value present in the cycle rd was high.
REQ-017 r_data SHALL equal mem[rd_ptr] combinationally when empty=0, and SHALL be all zeros when empty=1.
REQ-018 Write latency: a word pushed at edge N SHALL appear on r_data and deassert empty after edge N (zero extra cycles).
REQ-019 empty, full and level SHALL be registered and updated at the same edge as the pointer change; level SHALL increment by 1 on a push, decrement by 1 on a pop, and stay unchanged on simultaneous push and pop.
REQ-020 Not empty, not full, wr=1 and rd=1: the FIFO SHALL push and pop in the same cycle, and level SHALL be unchanged.
REQ-021 Full, wr=1, rd=0: the write SHALL be dropped, storage and pointers SHALL stay unchanged, and overrun SHALL set at that edge.
REQ-022 Full, wr=1, rd=1: the FIFO SHALL pop and push in the same cycle, full SHALL stay 1, and overrun SHALL NOT set.
REQ-023 Empty, rd=1: the read SHALL be ignored and no pointer or flag SHALL change; underflow is not flagged.
REQ-024 Empty, wr=1, rd=1: the write SHALL be accepted, the read SHALL be ignored, and the result SHALL be level=1.
REQ-025 overrun SHALL remain 1 until clr_overrun=1 clears it at a clock edge.
REQ-026 If a set condition and clr_overrun=1 occur in the same cycle, set SHALL win.
REQ-027 Pointer wrap-around SHALL be transparent: data order SHALL be preserved across the mem[2**ADDR_W-1] to mem[0] boundary.
REQ-028 The block SHALL contain no combinational path from wr to any output; empty, full, level and overrun are registers.

Reset
REQ-029 While rst=0, the block SHALL immediately and asynchronously force wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0 and overrun=0.
REQ-030 As a consequence of REQ-017, r_data SHALL be 0 during and after reset.
REQ-031 The storage array SHALL NOT be reset.
REQ-032 Reset asserted mid-operation SHALL discard all stored words.
REQ-033 The first push after rst returns to 1 SHALL land in mem[0].
REQ-034 wr or rd pulses coincident with the rising edge of rst SHALL be ignored for that edge.

Verification
REQ-035 Reset then idle -> empty=1, full=0, level=0, overrun=0, r_data=0x00.
REQ-036 Push 0xA5 then 0x3C, then pop twice -> r_data shows 0xA5 the cycle after the first push; after the first pop it shows 0x3C; after the second pop empty=1 and r_data=0x00.
REQ-037 Push 16 words 0x00..0x0F, then a 17th push of 0xFF with rd=0 -> full=1, level=16, overrun=1; popping all 16 yields 0x00..0x0F in order, and 0xFF is never seen.
REQ-038 With full=1, wr=1 and rd=1 carrying 0x77 -> level stays 16, overrun stays 0, and 0x77 is read last after draining.
REQ-039 Push/pop 40 words continuously (wrap twice) with random rd gaps -> output order matches input order and level never exceeds 16.
REQ-040 With 5 words stored, assert rst=0 mid-cycle -> outputs return to reset values without waiting for a clock edge; the next push of 0x11 reads back as 0x11.
